bn_param_loader: RTL

//  Writer side of the bn_relu_fp coefficient ports: accepts a serial stream of per-channel BN

---
 rtl/bn_param_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bn_param_loader.sv
// bn_param_loader: serial loader for per-channel BN scale/bias coefficients.
// Words arrive as a0,b0,a1,b1,... into a shadow bank; a complete, correctly
// framed set is committed atomically to the active a/b outputs once the
// datapath grants it through swap_ok.
module bn_param_loader #(
    parameter int NO_CH  = 1,
    parameter int BW_A   = 12,
    parameter int BW_B   = 12,
    parameter int BW_CFG = 12,
    parameter int DEBUG  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_vld,
    output logic                             cfg_rdy,
    input  logic [BW_CFG-1:0]                cfg_data,
    input  logic                             cfg_last,
    input  logic                             swap_ok,
    output logic [NO_CH-1:0][BW_A-1:0]       a,
    output logic [NO_CH-1:0][BW_B-1:0]       b,
    output logic                             param_vld,
    output logic                             swap_done,
    output logic                             cfg_err
);

    localparam int unsigned N_WORDS = 2 * NO_CH;
    localparam int unsigned CW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int unsigned LAST_W  = N_WORDS - 1;

    typedef enum logic {
        S_LOAD,
        S_PEND
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [CW-1:0]               w;
    logic [NO_CH-1:0][BW_A-1:0]  shadow_a;
    logic [NO_CH-1:0][BW_B-1:0]  shadow_b;
    logic                        accept;
    logic                        at_last;
    logic                        set_done;
    logic                        frame_err;
    logic                        commit;

    // Next-state and handshake decode; framing is checked on every accepted word.
    always_comb begin
        state_nxt = state;
        cfg_rdy   = 1'b0;
        accept    = 1'b0;
        set_done  = 1'b0;
        frame_err = 1'b0;
        commit    = 1'b0;
        at_last   = (w == CW'(LAST_W));
        case (state)
            S_LOAD: begin
                cfg_rdy = ~rst;
                accept  = cfg_vld & ~rst;
                if (accept) begin
                    if (cfg_last && at_last) begin
                        set_done  = 1'b1;
                        state_nxt = S_PEND;
                    end else if (cfg_last || at_last) begin
                        frame_err = 1'b1;
                    end
                end
            end
            S_PEND: begin
                if (swap_ok) begin
                    commit    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Word counter, shadow bank capture, atomic commit and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            w         <= '0;
            shadow_a  <= '0;
            shadow_b  <= '0;
            a         <= '0;
            b         <= '0;
            param_vld <= 1'b0;
            swap_done <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            swap_done <= commit;
            cfg_err   <= frame_err;
            if (accept) begin
                if (set_done || frame_err) begin
                    w <= '0;
                end else begin
                    w <= w + CW'(1);
                end
                for (int unsigned k = 0; k < NO_CH; k++) begin
                    if (w == CW'(2 * k)) begin
                        shadow_a[k] <= cfg_data[BW_A-1:0];
                    end
                    if (w == CW'(2 * k + 1)) begin
                        shadow_b[k] <= cfg_data[BW_B-1:0];
                    end
                end
            end
            if (commit) begin
                a         <= shadow_a;
                b         <= shadow_b;
                param_vld <= 1'b1;
            end
        end
    end

    // DEBUG only selects simulation-side tracing; it contributes no hardware.
    if (DEBUG != 0) begin : g_debug
    end

endmodule
